// File: rtl/vpx_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vpx_link_pkg
// Description : Shared types and constants for the VPX command link.
//               - link_state_t : direction/serializer FSM state encoding
//               - c_DEF_WORD_W / c_DEF_TURN_CYC : default parameter values
//               - beat_count() : 2-bit beats per frame for a given word width
//               Optional feature macro: VPX_LINK_PARITY_EN (adds a parity beat)
// Revision    : 1.0 - initial release
// ============================================================================
package vpx_link_pkg;

    localparam int c_DEF_WORD_W   = 16;
    localparam int c_DEF_TURN_CYC = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TURN_TX = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_TURN_RX = 2'd3
    } link_state_t;

    // Number of 2-bit beats in one frame on the wire.
    function automatic int beat_count(input int word_w);
`ifdef VPX_LINK_PARITY_EN
        return (word_w / 2) + 1;
`else
        return word_w / 2;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/vpx_cmd_rx_deser.sv
`default_nettype none
// ============================================================================
// Module      : vpx_cmd_rx_deser
// Description : 2-bit-beat receive deserializer for the VPX command link.
//               Shifts cmd_i_data in MSB pair first while sample_en is high,
//               strobes rx_valid after a complete frame, strobes rx_err when
//               the beat stream breaks mid-frame (or parity fails when
//               VPX_LINK_PARITY_EN is defined).
// Ports       : CLK, RST        clock / synchronous active-high reset
//               sample_en       bus released and FSM idle
//               cmd_i_dvld/data incoming beat
//               rx_valid/rx_data/rx_err  received word and strobes
//               rx_active       a frame is partially received
// Revision    : 1.0 - initial release
// ============================================================================
module vpx_cmd_rx_deser
    import vpx_link_pkg::*;
#(
    parameter int WORD_W = c_DEF_WORD_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              sample_en,
    input  logic              cmd_i_dvld,
    input  logic [1:0]        cmd_i_data,
    output logic              rx_valid,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_err,
    output logic              rx_active
);

    localparam int c_BEATS = beat_count(WORD_W);
    localparam int c_CW    = $clog2(c_BEATS + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_BEATS - 1);

    logic [c_CW-1:0]   r_cnt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;
    logic              r_err;
    logic [WORD_W-1:0] w_shift_next;

    assign w_shift_next = {r_shift[WORD_W-3:0], cmd_i_data};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (sample_en) begin
                if (cmd_i_dvld) begin
                    if (r_cnt == c_LAST) begin
                        r_cnt <= '0;
`ifdef VPX_LINK_PARITY_EN
                        // Final beat is the parity pair; r_shift already
                        // holds the complete data word.
                        if (cmd_i_data == {^r_shift, ~^r_shift}) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
`else
                        r_data  <= w_shift_next;
                        r_valid <= 1'b1;
`endif
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_shift <= w_shift_next;
                    end
                end else if (r_cnt != '0) begin
                    // Stream broke mid-frame: drop the partial word.
                    r_err <= 1'b1;
                    r_cnt <= '0;
                end
            end
        end
    end

    assign rx_valid  = r_valid;
    assign rx_data   = r_data;
    assign rx_err    = r_err;
    assign rx_active = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/vpx_cmd_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vpx_cmd_link_ctrl
// Description : Half-duplex 2-bit VPX command link controller. Round-robin
//               arbitration between host (bit0) and trigger responder (bit1),
//               bus turnaround / direction FSM, TX serializer, and an RX
//               deserializer sub-module (vpx_cmd_rx_deser).
//               Optional feature macro: VPX_LINK_PARITY_EN (parity beat).
// Ports       : CLK, RST                 clock / sync active-high reset
//               tx_valid/tx_data/tx_ready per-requester word handshake
//               cmd_dir                  1 = bus released, 0 = driven
//               cmd_o_dvld/cmd_o_data    outgoing beats
//               cmd_i_dvld/cmd_i_data    incoming beats
//               rx_valid/rx_data/rx_err  received word and strobes
//               busy                     FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module vpx_cmd_link_ctrl
    import vpx_link_pkg::*;
#(
    parameter int WORD_W   = c_DEF_WORD_W,
    parameter int TURN_CYC = c_DEF_TURN_CYC
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [1:0]          tx_valid,
    input  logic [2*WORD_W-1:0] tx_data,
    output logic [1:0]          tx_ready,
    output logic                cmd_dir,
    output logic                cmd_o_dvld,
    output logic [1:0]          cmd_o_data,
    input  logic                cmd_i_dvld,
    input  logic [1:0]          cmd_i_data,
    output logic                rx_valid,
    output logic [WORD_W-1:0]   rx_data,
    output logic                rx_err,
    output logic                busy
);

    localparam int c_BEATS = beat_count(WORD_W);
    localparam int c_TXW   = 2 * c_BEATS;
    localparam int c_BW    = $clog2(c_BEATS + 1);
    localparam int c_TW    = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [c_TW-1:0] c_TURN_LAST = c_TW'(TURN_CYC - 1);
    localparam logic [c_BW-1:0] c_BEAT_LAST = c_BW'(c_BEATS);

    link_state_t       r_state;
    logic              r_cmd_dir;
    logic              r_dvld;
    logic [1:0]        r_odata;
    logic              r_ptr;
    logic              r_ready_en;
    logic [c_TXW-1:0]  r_shift;
    logic [c_BW-1:0]   r_beat;
    logic [c_TW-1:0]   r_turn;

    logic              w_rx_active;
    logic              w_sample_en;
    logic              w_sel;
    logic              w_grant_ok;
    logic [1:0]        w_ready;
    logic              w_accept;
    logic [WORD_W-1:0] w_word;
    logic [c_TXW-1:0]  w_frame;

    // A sole requester wins outright; otherwise the pointer decides.
    always_comb begin
        w_sel = r_ptr;
        case (tx_valid)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
            default: w_sel = r_ptr;
        endcase
    end

    // r_ready_en holds grants off for the first cycle out of reset. An
    // incoming beat with the counter still at zero also blocks the grant so
    // a starting RX frame is never truncated by a TX turnaround.
    assign w_grant_ok = (r_state == ST_IDLE) && r_ready_en &&
                        !w_rx_active && !cmd_i_dvld;
    assign w_ready    = w_grant_ok ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
    assign w_accept   = |(tx_valid & w_ready);
    assign w_word     = w_sel ? tx_data[2*WORD_W-1:WORD_W] : tx_data[WORD_W-1:0];

`ifdef VPX_LINK_PARITY_EN
    assign w_frame = {w_word, ^w_word, ~^w_word};
`else
    assign w_frame = w_word;
`endif

    assign w_sample_en = (r_state == ST_IDLE) && r_cmd_dir;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cmd_dir  <= 1'b1;
            r_dvld     <= 1'b0;
            r_odata    <= '0;
            r_ptr      <= 1'b0;
            r_ready_en <= 1'b0;
            r_shift    <= '0;
            r_beat     <= '0;
            r_turn     <= '0;
        end else begin
            r_ready_en <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_cmd_dir <= 1'b1;
                    r_dvld    <= 1'b0;
                    r_odata   <= '0;
                    if (w_accept) begin
                        r_state   <= ST_TURN_TX;
                        r_cmd_dir <= 1'b0;
                        r_shift   <= w_frame;
                        r_ptr     <= ~w_sel;
                        r_turn    <= '0;
                    end
                end
                ST_TURN_TX: begin
                    if (r_turn == c_TURN_LAST) begin
                        r_state <= ST_SHIFT;
                        r_dvld  <= 1'b1;
                        r_odata <= r_shift[c_TXW-1 -: 2];
                        r_shift <= {r_shift[c_TXW-3:0], 2'b00};
                        r_beat  <= c_BW'(1);
                    end else begin
                        r_turn <= r_turn + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_beat == c_BEAT_LAST) begin
                        r_state <= ST_TURN_RX;
                        r_dvld  <= 1'b0;
                        r_odata <= '0;
                        r_turn  <= '0;
                    end else begin
                        r_odata <= r_shift[c_TXW-1 -: 2];
                        r_shift <= {r_shift[c_TXW-3:0], 2'b00};
                        r_beat  <= r_beat + 1'b1;
                    end
                end
                ST_TURN_RX: begin
                    if (r_turn == c_TURN_LAST) begin
                        r_state   <= ST_IDLE;
                        r_cmd_dir <= 1'b1;
                    end else begin
                        r_turn <= r_turn + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cmd_dir <= 1'b1;
                    r_dvld    <= 1'b0;
                    r_odata   <= '0;
                end
            endcase
        end
    end

    vpx_cmd_rx_deser #(
        .WORD_W (WORD_W)
    ) u_rx_deser (
        .CLK        (CLK),
        .RST        (RST),
        .sample_en  (w_sample_en),
        .cmd_i_dvld (cmd_i_dvld),
        .cmd_i_data (cmd_i_data),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_err     (rx_err),
        .rx_active  (w_rx_active)
    );

    assign tx_ready   = w_ready;
    assign cmd_dir    = r_cmd_dir;
    assign cmd_o_dvld = r_dvld;
    assign cmd_o_data = r_odata;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vpx_cmd_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vpx_cmd_link_ctrl
// Description : Directed self-checking bench for vpx_cmd_link_ctrl
//               (WORD_W=16, TURN_CYC=2). Honours VPX_LINK_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vpx_cmd_link_ctrl;

`ifdef VPX_LINK_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  tx_valid = 2'b00;
    logic [31:0] tx_data = '0;
    logic [1:0]  tx_ready;
    logic        cmd_dir;
    logic        cmd_o_dvld;
    logic [1:0]  cmd_o_data;
    logic        cmd_i_dvld = 1'b0;
    logic [1:0]  cmd_i_data = 2'b00;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    vpx_cmd_link_ctrl #(
        .WORD_W   (16),
        .TURN_CYC (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .cmd_dir    (cmd_dir),
        .cmd_o_dvld (cmd_o_dvld),
        .cmd_o_data (cmd_o_data),
        .cmd_i_dvld (cmd_i_dvld),
        .cmd_i_data (cmd_i_data),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_err     (rx_err),
        .busy       (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus only: send one RX frame, then release cmd_i_dvld.
    task automatic drive_rx(input logic [15:0] w, input logic [1:0] pbeat, input bit with_par);
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            cmd_i_dvld = 1'b1;
            cmd_i_data = w[15-2*i -: 2];
        end
        if (with_par) begin
            @(posedge CLK); #1;
            cmd_i_data = pbeat;
        end
        @(posedge CLK); #1;
        cmd_i_dvld = 1'b0;
        cmd_i_data = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge CLK); RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; tx_valid = 2'b01; tx_data = 32'h0000_1111;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if ({cmd_dir, cmd_o_dvld, cmd_o_data, busy} !== 5'b1_0_00_0) begin
            n_fail++; $display("FAIL reset_bus: dir/vld/data/busy got %b required 10000", {cmd_dir, cmd_o_dvld, cmd_o_data, busy});
        end
        n_checks++;
        if (tx_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b required 00", tx_ready);
        end
        n_checks++;
        if ({rx_valid, rx_err, rx_data} !== 18'h0) begin
            n_fail++; $display("FAIL reset_rx: valid/err/data got %b/%b/%h required 0/0/0000", rx_valid, rx_err, rx_data);
        end
        @(posedge CLK); #1;
        RST = 1'b0; tx_valid = 2'b00;
        @(negedge CLK);
        n_checks++;
        if (tx_ready !== 2'b00) begin
            n_fail++; $display("FAIL ready_deassert_cycle: got %b required 00", tx_ready);
        end
        @(negedge CLK);
        n_checks++;
        if (tx_ready !== 2'b01) begin
            n_fail++; $display("FAIL ready_first: got %b required 01", tx_ready);
        end
    endtask

    task automatic test_host_tx();
        logic [1:0] exp_beats [0:8];
        logic       ed, ev, eby;
        logic [1:0] er;
        exp_beats = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11, 2'b01};
        @(posedge CLK); #1;
        tx_data = 32'h0000_A5C3; tx_valid = 2'b01;
        @(negedge CLK);
        n_checks++;
        if (tx_ready !== 2'b01) begin
            n_fail++; $display("FAIL host_grant: got %b required 01", tx_ready);
        end
        @(posedge CLK); #1;
        tx_valid = 2'b00;
        for (int c = 1; c <= 5 + NB; c++) begin
            @(negedge CLK);
            ed  = (c > 4 + NB);
            ev  = (c >= 3) && (c <= 2 + NB);
            eby = (c <= 4 + NB);
            er  = (c > 4 + NB) ? 2'b10 : 2'b00;
            n_checks++;
            if ({cmd_dir, cmd_o_dvld, busy, tx_ready} !== {ed, ev, eby, er}) begin
                n_fail++; $display("FAIL host_tx_ctl cyc%0d: dir/vld/busy/rdy got %b required %b", c, {cmd_dir, cmd_o_dvld, busy, tx_ready}, {ed, ev, eby, er});
            end
            if (c <= 2 + NB) begin
                n_checks++;
                if (cmd_o_data !== ((c >= 3) ? exp_beats[c-3] : 2'b00)) begin
                    n_fail++; $display("FAIL host_tx_data cyc%0d: got %b required %b", c, cmd_o_data, (c >= 3) ? exp_beats[c-3] : 2'b00);
                end
            end
        end
    endtask

    task automatic test_rx();
        logic [1:0] b [0:8];
        b = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00, 2'b10};
        @(posedge CLK); #1;
        tx_valid = 2'b00;
        for (int i = 0; i < NB; i++) begin
            cmd_i_dvld = 1'b1; cmd_i_data = b[i];
            @(negedge CLK);
            n_checks++;
            if ({rx_valid, rx_err, tx_ready} !== 4'b0000) begin
                n_fail++; $display("FAIL rx_beat%0d: valid/err/rdy got %b required 0000", i, {rx_valid, rx_err, tx_ready});
            end
            @(posedge CLK); #1;
        end
        cmd_i_dvld = 1'b0; cmd_i_data = 2'b00;
        @(negedge CLK);
        n_checks++;
        if ({rx_valid, rx_err} !== 2'b10) begin
            n_fail++; $display("FAIL rx_strobe: valid/err got %b required 10", {rx_valid, rx_err});
        end
        n_checks++;
        if (rx_data !== 16'h1234) begin
            n_fail++; $display("FAIL rx_data: got %h required 1234", rx_data);
        end
        @(negedge CLK);
        n_checks++;
        if ({rx_valid, rx_err} !== 2'b00) begin
            n_fail++; $display("FAIL rx_strobe_width: valid/err got %b required 00", {rx_valid, rx_err});
        end
    endtask

    task automatic test_rx_err();
        int n;
        @(posedge CLK); #1;
        tx_data = 32'h0000_00F0; tx_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            cmd_i_dvld = 1'b1; cmd_i_data = 2'(i + 1);
            @(negedge CLK);
            n_checks++;
            if (tx_ready !== 2'b00) begin
                n_fail++; $display("FAIL rxerr_prio beat%0d: rdy got %b required 00", i, tx_ready);
            end
            @(posedge CLK); #1;
        end
        cmd_i_dvld = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({rx_err, rx_valid, tx_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL rxerr_drop: err/valid/rdy got %b required 0000", {rx_err, rx_valid, tx_ready});
        end
        @(negedge CLK);
        n_checks++;
        if ({rx_err, rx_valid, tx_ready} !== 4'b1001) begin
            n_fail++; $display("FAIL rxerr_pulse: err/valid/rdy got %b required 1001", {rx_err, rx_valid, tx_ready});
        end
        @(posedge CLK); #1;
        tx_valid = 2'b00;
        @(negedge CLK);
        n_checks++;
        if ({rx_err, busy} !== 2'b01) begin
            n_fail++; $display("FAIL rxerr_after: err/busy got %b required 01", {rx_err, busy});
        end
        // Junk on cmd_i while the block owns the bus must be ignored.
        n = 0;
        while (cmd_dir !== 1'b1 && n < 40) begin
            cmd_i_dvld = 1'b1; cmd_i_data = 2'($urandom_range(3));
            @(negedge CLK);
            n++;
        end
        cmd_i_dvld = 1'b0;
        n_checks++;
        if (n >= 40) begin
            n_fail++; $display("FAIL rxerr_frame_timeout: dir got %b required 1", cmd_dir);
        end
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({rx_err, rx_valid} !== 2'b00) begin
            n_fail++; $display("FAIL rx_ignore_busy: err/valid got %b required 00", {rx_err, rx_valid});
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_rdy [0:3];
        logic [15:0] exp_w   [0:3];
        logic [15:0] word;
        int n, nb;
        exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_w   = '{16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
        do_reset();
        tx_data = 32'hBEEF_1234; tx_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (tx_ready === 2'b00 && n < 40) begin
                @(negedge CLK); n++;
            end
            n_checks++;
            if (tx_ready !== exp_rdy[g]) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b required %b", g, tx_ready, exp_rdy[g]);
            end
            word = '0; nb = 0; n = 0;
            @(negedge CLK);
            while (cmd_dir === 1'b0 && n < 40) begin
                if (cmd_o_dvld === 1'b1 && nb < 8) begin
                    word = {word[13:0], cmd_o_data}; nb++;
                end
                n_checks++;
                if (tx_ready !== 2'b00) begin
                    n_fail++; $display("FAIL rr_ready_busy%0d: got %b required 00", g, tx_ready);
                end
                @(negedge CLK); n++;
            end
            n_checks++;
            if (word !== exp_w[g] || nb != 8) begin
                n_fail++; $display("FAIL rr_word%0d: got %h (%0d beats) required %h (8 beats)", g, word, nb, exp_w[g]);
            end
        end
        tx_valid = 2'b00;
    endtask

    task automatic test_reset_mid();
        int n, nb;
        bit bad;
        @(negedge CLK);
        tx_data = 32'h0000_5A5A; tx_valid = 2'b01;
        n = 0;
        while (tx_ready !== 2'b01 && n < 40) begin
            @(negedge CLK); n++;
        end
        @(posedge CLK); #1;
        tx_valid = 2'b00;
        nb = 0; n = 0;
        while (nb < 4 && n < 40) begin
            @(negedge CLK); n++;
            if (cmd_o_dvld === 1'b1) nb++;
        end
        n_checks++;
        if (nb != 4) begin
            n_fail++; $display("FAIL rstmid_beats: got %0d required 4", nb);
        end
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({cmd_dir, cmd_o_dvld, busy, tx_ready} !== 5'b10000) begin
            n_fail++; $display("FAIL rstmid_release: dir/vld/busy/rdy got %b required 10000", {cmd_dir, cmd_o_dvld, busy, tx_ready});
        end
        RST = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (cmd_o_dvld !== 1'b0 || cmd_dir !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL rstmid_no_retx: got bus activity required none");
        end
    endtask

`ifdef VPX_LINK_PARITY_EN
    task automatic test_parity();
        logic [1:0] beats [0:9];
        int n, nb;
        @(negedge CLK);
        tx_data = 32'h0000_0001; tx_valid = 2'b01;
        n = 0;
        while (tx_ready !== 2'b01 && n < 40) begin
            @(negedge CLK); n++;
        end
        @(posedge CLK); #1;
        tx_valid = 2'b00;
        nb = 0; n = 0;
        @(negedge CLK);
        while (cmd_dir === 1'b0 && n < 40) begin
            if (cmd_o_dvld === 1'b1 && nb < 10) begin
                beats[nb] = cmd_o_data; nb++;
            end
            @(negedge CLK); n++;
        end
        n_checks++;
        if (nb != 9) begin
            n_fail++; $display("FAIL par_tx_count: got %0d required 9", nb);
        end else begin
            n_checks++;
            if ({beats[7], beats[8]} !== 4'b0110) begin
                n_fail++; $display("FAIL par_tx_beat: beats 8/9 got %b required 0110", {beats[7], beats[8]});
            end
        end
        drive_rx(16'h1234, 2'b10, 1'b1);
        @(negedge CLK);
        n_checks++;
        if ({rx_valid, rx_err, rx_data} !== {2'b10, 16'h1234}) begin
            n_fail++; $display("FAIL par_rx_good: valid/err/data got %b/%b/%h required 1/0/1234", rx_valid, rx_err, rx_data);
        end
        drive_rx(16'hFFFF, 2'b10, 1'b1);
        @(negedge CLK);
        n_checks++;
        if ({rx_valid, rx_err, rx_data} !== {2'b01, 16'h1234}) begin
            n_fail++; $display("FAIL par_rx_bad: valid/err/data got %b/%b/%h required 0/1/1234", rx_valid, rx_err, rx_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_host_tx();
        test_rx();
        test_rx_err();
        test_round_robin();
        test_reset_mid();
`ifdef VPX_LINK_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
